alu_seq_ctrl: RTL



---
 rtl/alu_seq_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequential issuer / result collector for the combinational ALU.
// Accepts a request, runs the ALU N times (feeding each result back as A),
// owns the architectural flag register and returns the final result.
module alu_seq_ctrl #(
  parameter int OPER_W    = 5,
  parameter int FLAGS_W   = 4,
  parameter int PF_SLOT_C = 0,
  parameter int PF_SLOT_Z = 1
) (
  input  logic               clk,
  input  logic               reset,
  // request channel
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OPER_W-1:0]  req_oper,
  input  logic [7:0]         req_a_hi,
  input  logic [7:0]         req_a_lo,
  input  logic [7:0]         req_b,
  input  logic [3:0]         req_count,
  input  logic               req_flags_we,
  // direct flag register access
  input  logic               flags_wr_en,
  input  logic [FLAGS_W-1:0] flags_wr_data,
  output logic [FLAGS_W-1:0] flags,
  // ALU side
  output logic [OPER_W-1:0]  alu_oper,
  output logic [7:0]         alu_a_hi,
  output logic [7:0]         alu_a_lo,
  output logic [7:0]         alu_b,
  output logic [FLAGS_W-1:0] alu_flags_in,
  input  logic [7:0]         alu_out_hi,
  input  logic [7:0]         alu_out_lo,
  input  logic [FLAGS_W-1:0] alu_flags_out,
  // response channel
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_hi,
  output logic [7:0]         rsp_lo,
  output logic [FLAGS_W-1:0] rsp_flags
);

  // Carry and zero must name two distinct bits of the flag vector.
  if (PF_SLOT_C >= FLAGS_W || PF_SLOT_Z >= FLAGS_W || PF_SLOT_C == PF_SLOT_Z) begin : g_bad_slots
    $error("alu_seq_ctrl: PF_SLOT_C/PF_SLOT_Z must be distinct indices below FLAGS_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  state_t             r_state;
  logic [FLAGS_W-1:0] r_flags;
  logic [OPER_W-1:0]  r_oper;
  logic [15:0]        r_a;
  logic [7:0]         r_b;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [FLAGS_W-1:0] r_wflags;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [7:0]         r_rsp_hi;
  logic [7:0]         r_rsp_lo;
  logic [FLAGS_W-1:0] r_rsp_flags;

  // Working registers drive the ALU directly, so alu_* only move at edges.
  assign alu_oper     = r_oper;
  assign alu_a_hi     = r_a[15:8];
  assign alu_a_lo     = r_a[7:0];
  assign alu_b        = r_b;
  assign alu_flags_in = r_wflags;

  assign flags        = r_flags;
  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_hi       = r_rsp_hi;
  assign rsp_lo       = r_rsp_lo;
  assign rsp_flags    = r_rsp_flags;

  // Control FSM: accept, iterate the ALU, then hold the result until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_flags     <= '0;
      r_oper      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_wflags    <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_hi    <= '0;
      r_rsp_lo    <= '0;
      r_rsp_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flags_wr_en) begin
            r_flags <= flags_wr_data;
          end
          if (req_valid) begin
            r_oper      <= req_oper;
            r_a         <= {req_a_hi, req_a_lo};
            r_b         <= req_b;
            r_cnt       <= (req_count == 4'd0) ? 4'd1 : req_count;
            r_we        <= req_flags_we;
            // A same-cycle direct load is visible to the accepted op.
            r_wflags    <= flags_wr_en ? flags_wr_data : r_flags;
            r_req_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_a      <= {alu_out_hi, alu_out_lo};
          r_wflags <= alu_flags_out;
          if (r_we) begin
            r_flags <= alu_flags_out;
          end
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rsp_hi    <= alu_out_hi;
            r_rsp_lo    <= alu_out_lo;
            r_rsp_flags <= alu_flags_out;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
